// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
// The master drives the hazard and flush requests; the slave returns the stall and flush controls.
interface pipe_stall_ctrl_if #(
    parameter int LEN_W = 6
);
    logic             stallreq_id_i;
    logic             ex_multi_req_i;
    logic [LEN_W-1:0] ex_multi_len_i;
    logic             flush_req_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic             ex_busy_o;
    logic             multi_done_o;

    modport master (
        output stallreq_id_i, ex_multi_req_i, ex_multi_len_i, flush_req_i,
        input  stall_o, flush_o, ex_busy_o, multi_done_o
    );

    modport slave (
        input  stallreq_id_i, ex_multi_req_i, ex_multi_len_i, flush_req_i,
        output stall_o, flush_o, ex_busy_o, multi_done_o
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: turns load-use, multi-cycle EX and flush requests
// into a per-stage stall vector and a flush strobe for the five-stage core.
module pipe_stall_ctrl #(
    parameter int LEN_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_FRONT = 6'b000111;
    localparam logic [5:0] STALL_EX    = 6'b001111;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;

    state_t           w_nextState;
    logic [LEN_W-1:0] w_nextCnt;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic             w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Outputs are forced low during reset; the register block restores RUN on the same edge.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_stall     = STALL_NONE;
        w_flush     = 1'b0;
        w_done      = 1'b0;

        if (rst) begin
            w_nextState = RUN;
            w_nextCnt   = '0;
        end else if (bus.flush_req_i) begin
            w_flush     = 1'b1;
            w_nextCnt   = '0;
            w_nextState = FLUSH;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (bus.ex_multi_req_i && (bus.ex_multi_len_i > LEN_W'(1))) begin
                        w_stall     = STALL_EX;
                        w_nextCnt   = bus.ex_multi_len_i - LEN_W'(1);
                        w_nextState = MULTI;
                    end else if (bus.stallreq_id_i) begin
                        w_stall = STALL_FRONT;
                    end
                end
                MULTI: begin
                    // cnt counts the EX cycles still to come, including the current one.
                    if (r_cnt > LEN_W'(1)) begin
                        w_stall   = STALL_EX;
                        w_nextCnt = r_cnt - LEN_W'(1);
                    end else begin
                        w_done      = 1'b1;
                        w_nextCnt   = '0;
                        w_nextState = RUN;
                    end
                end
                FLUSH: begin
                    w_nextState = RUN;
                end
                default: begin
                    w_nextState = RUN;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    assign bus.stall_o      = w_stall;
    assign bus.flush_o      = w_flush;
    assign bus.multi_done_o = w_done;
    assign bus.ex_busy_o    = (r_state == MULTI) && !rst;

endmodule
